// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Every operation takes exactly 32 iterations after the accepting edge.
// Multiply uses radix-2 shift-add and divide uses restoring division, both on
// operand magnitudes. The sign is applied once, when the result is written.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,      // asynchronous, active-low
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    // hi/lo form the shared working register.
    // Multiply: product high half and multiplier/product low half.
    // Divide: partial remainder and dividend/quotient.
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic [XLEN-1:0] result_q, result_d;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] hi_step, lo_step;
    logic [2*XLEN-1:0] prod_mag, prod_fin;
    logic [XLEN-1:0] quo_fin, rem_fin;

    // Next-state, datapath iteration and final sign/result selection
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;

        // Operand signedness from funct3: MULH/MULHSU/DIV/REM treat rs1 as signed,
        // and only MULH/DIV/REM treat rs2 as signed.
        sign_a = rs1_data[XLEN-1] &
                 (op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10));
        sign_b = rs2_data[XLEN-1] &
                 (op[2] ? ~op[0] : (op[1:0] == 2'b01));
        mag_a  = sign_a ? -rs1_data : rs1_data;
        mag_b  = sign_b ? -rs2_data : rs2_data;

        // One multiply step: conditionally add the multiplicand, then shift right.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        // One restoring divide step: shift in the next dividend bit, then try to subtract.
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_step = div_diff[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_step = div_shift[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        prod_mag = {hi_step, lo_step};
        prod_fin = neg_q ? -prod_mag : prod_mag;
        quo_fin  = neg_q ? -lo_step : lo_step;
        rem_fin  = neg_q ? -hi_step : hi_step;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    count_d = '0;
                    op_d    = op;
                    hi_d    = '0;
                    if (op[2]) begin
                        lo_d   = mag_a;
                        opnd_d = mag_b;
                        // Divide by zero must return an all-ones quotient, which
                        // means the quotient is never negated. The remainder follows
                        // the sign of the dividend.
                        neg_d  = op[1] ? sign_a : ((sign_a ^ sign_b) & (rs2_data != '0));
                    end else begin
                        lo_d   = mag_b;
                        opnd_d = mag_a;
                        neg_d  = sign_a ^ sign_b;
                    end
                end
            end
            S_RUN: begin
                hi_d    = hi_step;
                lo_d    = lo_step;
                count_d = count_q + 1'b1;
                if (count_q == CW'(XLEN - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    case (op_q)
                        3'b000:  result_d = prod_fin[XLEN-1:0];
                        3'b001,
                        3'b010,
                        3'b011:  result_d = prod_fin[2*XLEN-1:XLEN];
                        3'b100,
                        3'b101:  result_d = quo_fin;
                        default: result_d = rem_fin;
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            count_q  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit. A 64-bit arithmetic reference model and a
// latency count are compared against every operation.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .result   (result),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model built from the RV32M arithmetic rules
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        int          ia, ib;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        r  = 32'd0;
        case (f)
            3'b000: begin p = ua * ub; r = p[31:0]; end
            3'b001: begin p = 64'(sa * sb); r = p[63:32]; end
            3'b010: begin p = 64'(sa * longint'(ub)); r = p[63:32]; end
            3'b011: begin p = ua * ub; r = p[63:32]; end
            3'b100: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = 32'(ia / ib);
            end
            3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'(ia % ib);
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one operation, count busy cycles, check latency and result.
    // A nonzero poke_at pulses start with fresh operands at that cycle of the run.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at, input logic [31:0] exp);
        int  n;
        bit  done;
        @(negedge clk);
        op = f; rs1_data = a; rs2_data = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs1_data = $urandom; rs2_data = $urandom; op = 3'($urandom);
        check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            if (poke_at != 0 && n == poke_at) begin
                start = 1'b1;
                rs1_data = $urandom; rs2_data = $urandom; op = 3'($urandom);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (!busy) done = 1'b1;
        end
        check({tag, " latency"}, 32'(n), 32'd32);
        check({tag, " result"}, result, exp);
        $display("op=%0d a=0x%08h b=0x%08h result=0x%08h expected=0x%08h cycles=%0d",
                 f, a, b, result, exp, n);
    endtask

    initial begin
        logic [31:0] a, b, held;
        logic [2:0]  f;

        reset = 1'b0; start = 1'b0; op = 3'd0; rs1_data = '0; rs2_data = '0;
        #23;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("MUL 7x6",        3'b000, 32'd7,          32'd6,          0, 32'd42);
        run_op("MULHU -1x-1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE);
        run_op("MULH -1x-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0000);
        run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,          0, 32'hFFFF_FFFD);
        run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,          0, 32'hFFFF_FFFF);
        run_op("DIVU 100/7",     3'b101, 32'd100,        32'd7,          0, 32'd14);
        run_op("REMU 100/7",     3'b111, 32'd100,        32'd7,          0, 32'd2);
        run_op("DIVU 5/0",       3'b101, 32'd5,          32'd0,          0, 32'hFFFF_FFFF);
        run_op("REM 5/0",        3'b110, 32'd5,          32'd0,          0, 32'd5);
        run_op("DIV -5/0",       3'b100, 32'hFFFF_FFFB, 32'd0,          0, 32'hFFFF_FFFF);
        run_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
        run_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);

        // A start pulse during a running MUL must be ignored
        run_op("MUL ignore_start", 3'b000, 32'h0001_2345, 32'h0000_0777, 10,
               ref_model(3'b000, 32'h0001_2345, 32'h0000_0777));

        // The result must hold across idle cycles
        held = result;
        repeat (5) @(posedge clk);
        #1;
        check("result hold", result, held);
        check("idle busy", {31'd0, busy}, 32'd0);

        // Randomized operations with corner values mixed in
        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'(b >> $urandom_range(0, 31));
                default: ;
            endcase
            run_op("random", f, a, b, 0, ref_model(f, a, b));
        end

        // Reset in the middle of a DIV aborts it and clears the result asynchronously
        @(negedge clk);
        op = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset result", result, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset held busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("after release busy", {31'd0, busy}, 32'd0);
        check("after release result", result, 32'd0);
        run_op("MULHSU -1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 0, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
